// File: rtl/read_frame_pkg.sv
// Shared types and constants for the read_frame capture block.
// READ_FRAME_TYPE_FILTER_EN adds the DISCARD state and ethertype filtering.
package read_frame_pkg;

  localparam logic [8:0]  MAX_LEN     = 9'd256;
  localparam logic [15:0] FILTER_TYPE = 16'h0800;

  typedef enum logic [1:0] {
    StWaitHdr,
    StRecv,
    StDone
`ifdef READ_FRAME_TYPE_FILTER_EN
    , StDiscard
`endif
  } state_e;

  function automatic logic type_accepted(input logic [15:0] eth_type);
    return eth_type == FILTER_TYPE;
  endfunction

endpackage

// File: rtl/read_frame_func_inner.sv
// Captures one Ethernet frame: header fields into registers, payload bytes into a buffer.
// Define READ_FRAME_TYPE_FILTER_EN to drop frames whose ethertype is not FILTER_TYPE.
module read_frame_func_inner
  import read_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  arg_0_raddr,
  output logic [7:0]  arg_0_waddr,
  output logic [7:0]  arg_0_wdata,
  output logic        arg_0_wen,
  input  logic [7:0]  arg_0_rdata,
  output logic        valid,
  output logic [8:0]  frame_len,
  output logic [15:0] frame_type,
  output logic [47:0] frame_src_mac,
  output logic        overflow,
  output logic        frame_err,
  input  logic        arg_2_m_eth_hdr_valid,
  output logic        arg_2_m_eth_hdr_ready,
  input  logic [47:0] arg_2_m_eth_dest_mac,
  input  logic [47:0] arg_2_m_eth_src_mac,
  input  logic [15:0] arg_2_m_eth_type,
  input  logic [7:0]  arg_2_m_eth_payload_axis_tdata,
  input  logic        arg_2_m_eth_payload_axis_tvalid,
  output logic        arg_2_m_eth_payload_axis_tready,
  input  logic        arg_2_m_eth_payload_axis_tlast,
  input  logic        arg_2_m_eth_payload_axis_tuser,
  input  logic        arg_2_busy
);

  state_e      state_q;
  logic [8:0]  count_q;
  logic [15:0] type_q;
  logic [47:0] src_q;
  logic        overflow_q, err_q, valid_q, hdr_ready_q, tready_q;
  logic        beat, room;
  logic        unused_inputs;

  assign unused_inputs = ^{arg_0_rdata, arg_2_m_eth_dest_mac, arg_2_busy};

  assign beat = arg_2_m_eth_payload_axis_tvalid & tready_q;
  assign room = (count_q != MAX_LEN);

  // Writes go out in the same cycle the beat is accepted.
  always_comb begin
    arg_0_wen = 1'b0;
    if ((state_q == StRecv) && beat && room) arg_0_wen = 1'b1;
  end

  assign arg_0_raddr = 8'd0;
  assign arg_0_waddr = count_q[7:0];
  assign arg_0_wdata = arg_2_m_eth_payload_axis_tdata;

  assign valid                           = valid_q;
  assign frame_len                       = count_q;
  assign frame_type                      = type_q;
  assign frame_src_mac                   = src_q;
  assign overflow                        = overflow_q;
  assign frame_err                       = err_q;
  assign arg_2_m_eth_hdr_ready           = hdr_ready_q;
  assign arg_2_m_eth_payload_axis_tready = tready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StWaitHdr;
      count_q     <= '0;
      type_q      <= '0;
      src_q       <= '0;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      hdr_ready_q <= 1'b1;
      tready_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StWaitHdr: begin
          if (arg_2_m_eth_hdr_valid) begin
            hdr_ready_q <= 1'b0;
            tready_q    <= 1'b1;
`ifdef READ_FRAME_TYPE_FILTER_EN
            if (!type_accepted(arg_2_m_eth_type)) state_q <= StDiscard;
            else
`endif
            begin
              state_q    <= StRecv;
              type_q     <= arg_2_m_eth_type;
              src_q      <= arg_2_m_eth_src_mac;
              count_q    <= '0;
              overflow_q <= 1'b0;
              err_q      <= 1'b0;
            end
          end
        end
        StRecv: begin
          if (beat) begin
            // Count saturates at MAX_LEN; extra bytes only raise overflow.
            if (room) count_q <= count_q + 9'd1;
            else      overflow_q <= 1'b1;
            if (arg_2_m_eth_payload_axis_tlast) begin
              err_q    <= arg_2_m_eth_payload_axis_tuser;
              state_q  <= StDone;
              tready_q <= 1'b0;
              valid_q  <= 1'b1;
            end
          end
        end
`ifdef READ_FRAME_TYPE_FILTER_EN
        StDiscard: begin
          if (beat && arg_2_m_eth_payload_axis_tlast) begin
            state_q     <= StWaitHdr;
            tready_q    <= 1'b0;
            hdr_ready_q <= 1'b1;
          end
        end
`endif
        StDone: ;
        default: begin
          state_q     <= StWaitHdr;
          hdr_ready_q <= 1'b1;
          tready_q    <= 1'b0;
          valid_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/read_frame_func.sv
// Top-level wrapper for the frame capture core; optional READ_FRAME_TYPE_FILTER_EN
// ethertype filtering lives in read_frame_func_inner.
module read_frame_func (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  arg_0_raddr,
  output logic [7:0]  arg_0_waddr,
  output logic [7:0]  arg_0_wdata,
  output logic        arg_0_wen,
  input  logic [7:0]  arg_0_rdata,
  output logic        valid,
  output logic [8:0]  frame_len,
  output logic [15:0] frame_type,
  output logic [47:0] frame_src_mac,
  output logic        overflow,
  output logic        frame_err,
  input  logic        arg_2_m_eth_hdr_valid,
  output logic        arg_2_m_eth_hdr_ready,
  input  logic [47:0] arg_2_m_eth_dest_mac,
  input  logic [47:0] arg_2_m_eth_src_mac,
  input  logic [15:0] arg_2_m_eth_type,
  input  logic [7:0]  arg_2_m_eth_payload_axis_tdata,
  input  logic        arg_2_m_eth_payload_axis_tvalid,
  output logic        arg_2_m_eth_payload_axis_tready,
  input  logic        arg_2_m_eth_payload_axis_tlast,
  input  logic        arg_2_m_eth_payload_axis_tuser,
  input  logic        arg_2_busy
);

  read_frame_func_inner u_inner (
    .clk                             (clk),
    .rst                             (rst),
    .arg_0_raddr                     (arg_0_raddr),
    .arg_0_waddr                     (arg_0_waddr),
    .arg_0_wdata                     (arg_0_wdata),
    .arg_0_wen                       (arg_0_wen),
    .arg_0_rdata                     (arg_0_rdata),
    .valid                           (valid),
    .frame_len                       (frame_len),
    .frame_type                      (frame_type),
    .frame_src_mac                   (frame_src_mac),
    .overflow                        (overflow),
    .frame_err                       (frame_err),
    .arg_2_m_eth_hdr_valid           (arg_2_m_eth_hdr_valid),
    .arg_2_m_eth_hdr_ready           (arg_2_m_eth_hdr_ready),
    .arg_2_m_eth_dest_mac            (arg_2_m_eth_dest_mac),
    .arg_2_m_eth_src_mac             (arg_2_m_eth_src_mac),
    .arg_2_m_eth_type                (arg_2_m_eth_type),
    .arg_2_m_eth_payload_axis_tdata  (arg_2_m_eth_payload_axis_tdata),
    .arg_2_m_eth_payload_axis_tvalid (arg_2_m_eth_payload_axis_tvalid),
    .arg_2_m_eth_payload_axis_tready (arg_2_m_eth_payload_axis_tready),
    .arg_2_m_eth_payload_axis_tlast  (arg_2_m_eth_payload_axis_tlast),
    .arg_2_m_eth_payload_axis_tuser  (arg_2_m_eth_payload_axis_tuser),
    .arg_2_busy                      (arg_2_busy)
  );

endmodule
